// File: rtl/frame_streamer_pkg.sv
// Shared types and default geometry for the frame streamer.
// Index widths never collapse to zero, so degenerate 1-row or 1-col frames still elaborate.
package frame_streamer_pkg;

    function automatic int idx_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

    localparam int ROWS_DEF  = 16;
    localparam int COLS_DEF  = 8;
    localparam int DW_DEF    = 8;
    localparam int N_DEF     = ROWS_DEF * COLS_DEF;
    localparam int CNT_W_DEF = idx_width(N_DEF);
    localparam int ROW_W_DEF = idx_width(ROWS_DEF);
    localparam int COL_W_DEF = idx_width(COLS_DEF);

    typedef enum logic {
        LOAD = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/frame_streamer_buf.sv
// Purpose: DEPTH x DW frame store, one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after it is clocked in.
// Backpressure: none; the caller gates wr_en.
module frame_streamer_buf #(
    parameter int DEPTH = 128,
    parameter int DW    = 8,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Pixel storage is deliberately left unreset; a frame is always fully rewritten before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/frame_streamer.sv
// Purpose: buffer one ROWS x COLS frame, then stream it in raster order with row/col and SOF/EOF.
// Latency: first beat the cycle after the last pixel is accepted; N beats with out_ready held high.
// Backpressure: in_ready low while streaming; out_ready low freezes the current beat.
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DW-1:0]              in_data,
    output logic                       in_ready,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic [idx_width(ROWS)-1:0] out_row,
    output logic [idx_width(COLS)-1:0] out_col,
    output logic                       out_sof,
    output logic                       out_eof,
    output logic                       frame_done
);

    localparam int N_PIX = ROWS * COLS;
    localparam int CNT_W = idx_width(N_PIX);
    localparam int ROW_W = idx_width(ROWS);
    localparam int COL_W = idx_width(COLS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wr_cnt, wr_cnt_nxt;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_nxt;
    logic             frame_done_nxt;
    logic             wr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_cnt     <= wr_cnt_nxt;
            rd_cnt     <= rd_cnt_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wr_cnt_nxt     = wr_cnt;
        rd_cnt_nxt     = rd_cnt;
        frame_done_nxt = 1'b0;
        wr_en          = 1'b0;
        in_ready       = 1'b0;
        out_valid      = 1'b0;

        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt == LAST) begin
                        wr_cnt_nxt = '0;
                        rd_cnt_nxt = '0;
                        state_nxt  = SEND;
                    end else begin
                        wr_cnt_nxt = wr_cnt + ONE;
                    end
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (rd_cnt == LAST) begin
                        rd_cnt_nxt     = '0;
                        state_nxt      = LOAD;
                        frame_done_nxt = 1'b1;
                    end else begin
                        rd_cnt_nxt = rd_cnt + ONE;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase

        // Abort discards the whole frame, including whatever happened this cycle.
        if (abort) begin
            state_nxt      = LOAD;
            wr_cnt_nxt     = '0;
            rd_cnt_nxt     = '0;
            frame_done_nxt = 1'b0;
            wr_en          = 1'b0;
        end
    end

    frame_streamer_buf #(
        .DEPTH (N_PIX),
        .DW    (DW),
        .AW    (CNT_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt),
        .wr_data (in_data),
        .rd_addr (rd_cnt),
        .rd_data (out_data)
    );

    assign out_row = ROW_W'(int'(rd_cnt) / COLS);
    assign out_col = COL_W'(int'(rd_cnt) % COLS);
    assign out_sof = out_valid && (rd_cnt == '0);
    assign out_eof = out_valid && (rd_cnt == LAST);

endmodule

// File: tb/tb_frame_streamer.sv
// Randomised bench for frame_streamer against a frame-level queue model.
module tb_frame_streamer;

    localparam int ROWS = 16;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int N    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [3:0]    out_row;
    logic [2:0]    out_col;
    logic          out_sof;
    logic          out_eof;
    logic          frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Model: pixels collected for the current frame, whether it is being replayed, and the beat index.
    logic [DW-1:0] q[$];
    bit            m_send;
    int            m_k;
    bit            m_done;

    always #5 clk = ~clk;

    frame_streamer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_send = 0;
        m_k    = 0;
        m_done = 0;
    endtask

    task automatic model_step();
        if (abort) begin
            model_reset();
        end else if (!m_send) begin
            m_done = 0;
            if (in_valid) begin
                q.push_back(in_data);
                if (q.size() == N) begin
                    m_send = 1;
                    m_k    = 0;
                end
            end
        end else begin
            m_done = 0;
            if (out_ready) begin
                m_k++;
                if (m_k == N) begin
                    q.delete();
                    m_send = 0;
                    m_k    = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("in_ready", in_ready, !m_send);
        chk("out_valid", out_valid, m_send);
        chk("frame_done", frame_done, m_done);
        if (m_send) begin
            chk("out_data", out_data, q[m_k]);
            chk("out_row", out_row, m_k / COLS);
            chk("out_col", out_col, m_k % COLS);
            chk("out_sof", out_sof, m_k == 0);
            chk("out_eof", out_eof, m_k == N - 1);
        end
    endtask

    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic ordy, input logic ab);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        abort     = ab;
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    // gaps: in_valid drops every third cycle.
    task automatic load_n(input int n, input int base, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 1000) begin
            logic v;
            v = gaps ? ((guard % 3) != 2) : 1'b1;
            cycle(v, DW'(base + i), 1'b1, 1'b0);
            if (v) i++;
            guard++;
        end
        chk("load_timeout", i, n);
    endtask

    // mode 0: ready held high, 1: ready toggles 1,0,..., 2: random ready.
    task automatic stream_until(input int mode, input int stop_k);
        int guard = 0;
        while (m_send && m_k < stop_k && guard < 2000) begin
            logic r;
            r = (mode == 0) ? 1'b1 : (mode == 1) ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
            cycle(1'($urandom_range(0, 1)), 8'($urandom), r, 1'b0);
            guard++;
        end
        chk("stream_timeout", guard < 2000, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_data = 0; out_ready = 0; abort = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare_all();

        // Straight frame 0..127, free-running consumer.
        load_n(N, 0, 0);
        chk("first_beat", out_data, 0);
        stream_until(0, N);
        chk("done_pulse", frame_done, 1);
        idle(1);
        chk("done_cleared", frame_done, 0);

        // Same frame, consumer stalling every other cycle.
        load_n(N, 0, 0);
        stream_until(1, N);
        idle(2);

        // Gappy load of random data, random consumer.
        load_n(N, $urandom_range(0, 255), 1);
        stream_until(2, N);
        idle(1);

        // Abort after 50 pixels, then a fresh frame starting at 200.
        load_n(50, 7, 0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b1);
        load_n(N, 200, 0);
        chk("fresh_first", out_data, 200);
        stream_until(2, N);
        idle(1);

        // Abort coinciding with the final accept keeps the block in LOAD.
        load_n(N - 1, 3, 0);
        cycle(1'b1, 8'h55, 1'b1, 1'b1);
        chk("abort_last_accept", out_valid, 0);

        // Abort mid-stream at beat 64.
        load_n(N, 90, 0);
        stream_until(0, 64);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("abort_send_ov", out_valid, 0);
        chk("abort_send_ir", in_ready, 1);
        chk("abort_send_fd", frame_done, 0);

        // Abort coinciding with the final beat: no frame_done.
        load_n(N, 11, 0);
        stream_until(0, N - 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("abort_last_beat_fd", frame_done, 0);

        // Asynchronous reset mid-stream, off the clock edge.
        load_n(N, 33, 0);
        stream_until(2, 20);
        #2 reset = 1'b1;
        #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_fd", frame_done, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();

        // Asynchronous reset while frame_done is high.
        load_n(N, $urandom_range(0, 255), 0);
        stream_until(0, N);
        chk("pre_arst_fd", frame_done, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_fd_pulse", frame_done, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Full random frame after reset.
        load_n(N, $urandom_range(0, 255), 1);
        stream_until(2, N);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
